// File: rtl/ts_os_checker.sv
// ts_os_checker: classifies Gen1/Gen2 ordered sets as TS1/TS2/other, checks cross-lane
// consistency and lane numbering, and counts consecutive identical training sets.
module ts_os_checker #(
  parameter int TS_THRESHOLD = 8,
  parameter int MAX_LANES    = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [2:0]                 gen,
  input  logic [4:0]                 numberOfDetectedLanes,
  input  logic                       osValidIn,
  input  logic [128*MAX_LANES-1:0]   osIn,
  input  logic                       clearCount,
  output logic                       osValid,
  output logic [1:0]                 osType,
  output logic [3:0]                 tsCount,
  output logic                       tsDone,
  output logic [7:0]                 linkNum,
  output logic [7:0]                 nFts,
  output logic [7:0]                 dataRate,
  output logic [7:0]                 trainCtrl,
  output logic                       linkPad,
  output logic                       lanePad,
  output logic                       laneOrderOk,
  output logic                       laneReversed
);
  function automatic logic [1:0] cls_of(input logic [127:0] s);
    return (s[7:0] != 8'hBC) ? 2'd3 :
           (s[127:48] == {10{8'h4A}}) ? 2'd1 :
           (s[127:48] == {10{8'h45}}) ? 2'd2 : 2'd3;
  endfunction
  logic [4:0]   n_act;
  logic [1:0]   cls0, type_d;
  logic         cons_d, order_d, rev_d, lpad_d, accept, hit;
  logic [127:0] sl;
  logic [33:0]  key_d, key_q;
  logic         key_vld_q, prev_cons_q;
  logic [3:0]   cnt_d;
  assign n_act = (numberOfDetectedLanes == 5'd1 || numberOfDetectedLanes == 5'd2 ||
                  numberOfDetectedLanes == 5'd4 || numberOfDetectedLanes == 5'd8 ||
                  numberOfDetectedLanes == 5'd16) ? numberOfDetectedLanes : 5'd1;
  assign accept = osValidIn && (gen == 3'd1 || gen == 3'd2);
  always_comb begin
    cls0    = cls_of(osIn[127:0]);
    cons_d  = cls0 != 2'd3;
    order_d = 1'b1;
    rev_d   = 1'b1;
    lpad_d  = 1'b1;
    sl      = '0;
    for (int l = 0; l < MAX_LANES; l++) begin
      if (l < int'(n_act)) begin
        sl = osIn[128*l +: 128];
        if (cls_of(sl) != cls0 || sl[47:24] != osIn[47:24] || sl[15:8] != osIn[15:8]) cons_d = 1'b0;
        if (sl[23:16] != 8'(l)) order_d = 1'b0;
        if (sl[23:16] != 8'(int'(n_act) - 1 - l)) rev_d = 1'b0;
        if (sl[23:16] != 8'hF7) lpad_d = 1'b0;
      end
    end
  end
  assign type_d = cons_d ? cls0 : 2'd3;
  assign key_d  = {type_d, osIn[47:24], osIn[15:8]};
  // A pending clear breaks the run even when an OS arrives in the same cycle
  assign hit    = cons_d && key_vld_q && prev_cons_q && key_d == key_q && !clearCount;
  assign cnt_d  = !cons_d ? 4'd0 : hit ? ((tsCount == 4'd15) ? 4'd15 : tsCount + 4'd1) : 4'd1;
  assign tsDone = int'(tsCount) >= TS_THRESHOLD;
  always_ff @(posedge clk) begin
    if (reset) begin
      osValid      <= 1'b0;
      osType       <= 2'd0;
      tsCount      <= 4'd0;
      linkNum      <= 8'd0;
      nFts         <= 8'd0;
      dataRate     <= 8'd0;
      trainCtrl    <= 8'd0;
      linkPad      <= 1'b0;
      lanePad      <= 1'b0;
      laneOrderOk  <= 1'b0;
      laneReversed <= 1'b0;
      key_q        <= '0;
      key_vld_q    <= 1'b0;
      prev_cons_q  <= 1'b0;
    end else begin
      osValid <= accept;
      if (accept) begin
        osType       <= type_d;
        tsCount      <= cnt_d;
        linkNum      <= osIn[15:8];
        nFts         <= osIn[31:24];
        dataRate     <= osIn[39:32];
        trainCtrl    <= osIn[47:40];
        linkPad      <= osIn[15:8] == 8'hF7;
        lanePad      <= lpad_d;
        laneOrderOk  <= order_d;
        laneReversed <= rev_d;
        key_q        <= key_d;
        key_vld_q    <= 1'b1;
        prev_cons_q  <= cons_d;
      end else if (clearCount) begin
        tsCount   <= 4'd0;
        key_vld_q <= 1'b0;
      end else if (osValidIn) begin
        tsCount     <= 4'd0;
        prev_cons_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ts_os_checker.sv
// tb_ts_os_checker: table-driven directed bench for ts_os_checker.
module tb_ts_os_checker;
  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    gen;
  logic [4:0]    nd;
  logic          os_valid_in, clear_count;
  logic [2047:0] os_in;
  logic          os_valid, ts_done, link_num_pad, lane_pad, lane_order_ok, lane_reversed;
  logic [1:0]    os_type;
  logic [3:0]    ts_count;
  logic [7:0]    link_num, n_fts, data_rate, train_ctrl;
  int            nchk = 0, nerr = 0;

  always #5 clk = ~clk;

  ts_os_checker #(.TS_THRESHOLD(8), .MAX_LANES(16)) dut (
    .clk(clk), .reset(reset), .gen(gen), .numberOfDetectedLanes(nd),
    .osValidIn(os_valid_in), .osIn(os_in), .clearCount(clear_count),
    .osValid(os_valid), .osType(os_type), .tsCount(ts_count), .tsDone(ts_done),
    .linkNum(link_num), .nFts(n_fts), .dataRate(data_rate), .trainCtrl(train_ctrl),
    .linkPad(link_num_pad), .lanePad(lane_pad), .laneOrderOk(lane_order_ok),
    .laneReversed(lane_reversed)
  );

  typedef struct {
    logic [2:0] gen;
    logic [4:0] n;
    logic       v, clr;
    logic [1:0] t;
    logic [7:0] link, nfts;
    logic [1:0] mode, tw;
    logic       ov;
    logic [1:0] ot;
    logic [3:0] cnt;
    logic       done, ord, rev, lp, lnp;
  } row_t;
  row_t rows[$];

  function automatic row_t mk(logic [2:0] g, logic [4:0] n, logic v, logic clr, logic [1:0] t,
                              logic [7:0] link, logic [7:0] nfts, logic [1:0] mode, logic [1:0] tw,
                              logic ov, logic [1:0] ot, logic [3:0] cnt, logic done,
                              logic ord, logic rev, logic lp, logic lnp);
    row_t r;
    r.gen = g; r.n = n; r.v = v; r.clr = clr; r.t = t; r.link = link; r.nfts = nfts;
    r.mode = mode; r.tw = tw; r.ov = ov; r.ot = ot; r.cnt = cnt; r.done = done;
    r.ord = ord; r.rev = rev; r.lp = lp; r.lnp = lnp;
    return r;
  endfunction

  // mode 0: lane L numbered L, 1: numbered n-1-L, 2: PAD lane numbers
  function automatic logic [2047:0] build(logic [4:0] n, logic [1:0] t, logic [7:0] link,
                                          logic [7:0] nfts, logic [1:0] mode);
    logic [2047:0] b;
    logic [7:0]    ln;
    b = '0;
    for (int l = 0; l < 16; l++) begin
      ln = (mode == 2'd0) ? 8'(l) : (mode == 2'd1) ? 8'(int'(n) - 1 - l) : 8'hF7;
      b[128*l +: 48] = {8'h00, 8'h02, nfts, ln, link, 8'hBC};
      b[128*l+48 +: 80] = (t == 2'd1) ? {10{8'h4A}} : {10{8'h45}};
    end
    return b;
  endfunction

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  initial begin
    row_t r;
    reset = 1'b1; gen = 3'd1; nd = 5'd2; os_valid_in = 1'b0; clear_count = 1'b0; os_in = '0;
    // Test plan sequences with hand-computed expectations
    for (int i = 0; i < 8; i++)
      rows.push_back(mk(1, 2, 1, 0, 1, 8'h00, 8'h10, 0, 0, 1, 1, 4'(i + 1), i + 1 >= 8, 1, 0, 0, 0));
    for (int i = 0; i < 5; i++)
      rows.push_back(mk(2, 4, 1, 0, 2, 8'h00, 8'h10, 1, 0, 1, 2, 4'(i + 1), 0, 0, 1, 0, 0));
    for (int i = 0; i < 3; i++)
      rows.push_back(mk(1, 1, 1, 0, 1, 8'h00, 8'h10, 0, 0, 1, 1, 4'(i + 1), 0, 1, 1, 0, 0));
    rows.push_back(mk(1, 1, 1, 0, 1, 8'h00, 8'h11, 0, 0, 1, 1, 1, 0, 1, 1, 0, 0));
    rows.push_back(mk(1, 1, 1, 0, 1, 8'h00, 8'h11, 0, 1, 1, 3, 0, 0, 1, 1, 0, 0));
    for (int i = 0; i < 2; i++)
      rows.push_back(mk(1, 8, 1, 0, 1, 8'hF7, 8'h10, 2, 0, 1, 1, 4'(i + 1), 0, 0, 0, 1, 1));
    rows.push_back(mk(1, 8, 1, 0, 1, 8'hF7, 8'h10, 2, 2, 1, 3, 0, 0, 0, 0, 1, 1));
    for (int i = 0; i < 3; i++)
      rows.push_back(mk(1, 2, 1, 0, 1, 8'h00, 8'h10, 0, 0, 1, 1, 4'(i + 1), 0, 1, 0, 0, 0));
    rows.push_back(mk(1, 2, 1, 1, 1, 8'h00, 8'h10, 0, 0, 1, 1, 1, 0, 1, 0, 0, 0));
    rows.push_back(mk(1, 2, 0, 1, 1, 8'h00, 8'h10, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0));
    rows.push_back(mk(1, 2, 1, 0, 1, 8'h00, 8'h10, 0, 0, 1, 1, 1, 0, 1, 0, 0, 0));
    for (int i = 0; i < 5; i++)
      rows.push_back(mk(1, 2, 1, 0, 1, 8'h00, 8'h10, 0, 0, 1, 1, 4'(i + 2), 0, 1, 0, 0, 0));
    rows.push_back(mk(1, 2, 1, 0, 1, 8'h00, 8'h10, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(3, 2, 1, 0, 1, 8'h00, 8'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, 3, 1, 0, 1, 8'h00, 8'h10, 0, 0, 1, 1, 1, 0, 1, 1, 0, 0));
    rows.push_back(mk(2, 3, 1, 0, 1, 8'h00, 8'h10, 0, 0, 1, 1, 2, 0, 1, 1, 0, 0));
    rows.push_back(mk(0, 3, 1, 0, 1, 8'h00, 8'h10, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0));
    for (int i = 0; i < 16; i++)
      rows.push_back(mk(1, 16, 1, 0, 1, 8'h00, 8'h10, 0, 0, 1, 1, (i + 1 > 15) ? 4'd15 : 4'(i + 1),
                        i + 1 >= 8, 1, 0, 0, 0));

    repeat (2) @(posedge clk);
    #1;
    chk("rst_osValid", 32'(os_valid), 0);
    chk("rst_osType", 32'(os_type), 0);
    chk("rst_tsCount", 32'(ts_count), 0);
    chk("rst_tsDone", 32'(ts_done), 0);
    chk("rst_flags", {28'd0, link_num_pad, lane_pad, lane_order_ok, lane_reversed}, 0);
    reset = 1'b0;

    for (int k = 0; k < rows.size(); k++) begin
      r = rows[k];
      gen = r.gen; nd = r.n; os_valid_in = r.v; clear_count = r.clr;
      os_in = build(r.n, r.t, r.link, r.nfts, r.mode);
      if (r.tw == 2'd1) os_in[64 +: 8] = 8'h00;
      if (r.tw == 2'd2) os_in[128*5+48 +: 80] = {10{8'h45}};
      reset = (r.tw == 2'd3);
      @(posedge clk);
      #1;
      chk($sformatf("r%0d_osValid", k), 32'(os_valid), 32'(r.ov));
      chk($sformatf("r%0d_osType", k), 32'(os_type), 32'(r.ot));
      chk($sformatf("r%0d_tsCount", k), 32'(ts_count), 32'(r.cnt));
      chk($sformatf("r%0d_tsDone", k), 32'(ts_done), 32'(r.done));
      chk($sformatf("r%0d_laneOrderOk", k), 32'(lane_order_ok), 32'(r.ord));
      chk($sformatf("r%0d_laneReversed", k), 32'(lane_reversed), 32'(r.rev));
      chk($sformatf("r%0d_linkPad", k), 32'(link_num_pad), 32'(r.lp));
      chk($sformatf("r%0d_lanePad", k), 32'(lane_pad), 32'(r.lnp));
      if (r.ov) begin
        chk($sformatf("r%0d_fields", k), {link_num, n_fts, data_rate, train_ctrl},
            {r.link, r.nfts, 8'h02, 8'h00});
      end
    end

    // Fields must hold across idle cycles after an accepted OS
    reset = 1'b0; gen = 3'd2; nd = 5'd1; os_valid_in = 1'b1; clear_count = 1'b0;
    os_in = build(5'd1, 2'd2, 8'h05, 8'h33, 2'd0);
    @(posedge clk);
    #1;
    os_valid_in = 1'b0;
    os_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("hold_osValid", 32'(os_valid), 0);
    chk("hold_fields", {link_num, n_fts, data_rate}, {8'h05, 8'h33, 8'h02});
    chk("hold_osType", 32'(os_type), 2);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
